inst_fetch_unit: RTL

//   Instruction fetch front end for the RISC-V core. Owns the fetch PC and issues

---
 rtl/inst_fetch_unit_if.sv | 22 ++
 rtl/inst_fetch_unit.sv | 124 ++++++++++++
 2 files changed

// File: rtl/inst_fetch_unit_if.sv
// Fetch unit bus bundle: instruction-memory req/ack channel and decode valid/ready channel.
// The master modport is the fetch unit; the slave side is memory plus decode.
interface inst_fetch_unit_if;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_ack_i;
  logic [31:0] mem_rdata_i;
  logic        inst_valid_o;
  logic [31:0] inst_o;
  logic [31:0] inst_pc_o;
  logic        inst_ready_i;

  modport master (
    output mem_req_o, mem_addr_o, inst_valid_o, inst_o, inst_pc_o,
    input  mem_ack_i, mem_rdata_i, inst_ready_i
  );

  modport slave (
    input  mem_req_o, mem_addr_o, inst_valid_o, inst_o, inst_pc_o,
    output mem_ack_i, mem_rdata_i, inst_ready_i
  );
endinterface

// File: rtl/inst_fetch_unit.sv
// Instruction fetch front end: owns the fetch PC, reads words over req/ack, queues them
// with their PCs and hands them to decode over valid/ready; redirects flush the queue.
module inst_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic               redirect_i,
  input  logic [31:0]        redirect_pc_i,
  inst_fetch_unit_if.master  bus
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, FETCH, WAIT, DRAIN} state_e;

  state_e        state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   drain_addr_q, drain_addr_d;
  logic [CW-1:0] count_q, count_d, count_nx;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [31:0]   inst_mem_q [DEPTH];
  logic [31:0]   pc_mem_q   [DEPTH];

  logic        req;
  logic        push_ok, pop_ok;
  logic        flush, push, pop;
  logic        head_vld;
  logic [31:0] redir_pc;

  assign redir_pc = {redirect_pc_i[31:2], 2'b00};
  assign req      = (state_q == FETCH) || (state_q == DRAIN);
  assign push_ok  = (state_q == FETCH) && bus.mem_ack_i;
  assign head_vld = (count_q != '0);
  assign pop_ok   = head_vld && bus.inst_ready_i;
  assign count_nx = count_q + CW'(push_ok) - CW'(pop_ok);

  // A redirect outside IDLE discards whatever push or pop would happen this cycle.
  assign flush = redirect_i && (state_q != IDLE);
  assign push  = push_ok && !flush;
  assign pop   = pop_ok && !flush;

  always_comb begin
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    drain_addr_d = drain_addr_q;
    case (state_q)
      IDLE: begin
        if (start_i) state_d = FETCH;
      end
      FETCH, WAIT: begin
        if (flush) begin
          fetch_pc_d = redir_pc;
          // An unanswered request must still be completed on the bus before refetching.
          if (req && !bus.mem_ack_i) begin
            state_d      = DRAIN;
            drain_addr_d = fetch_pc_q;
          end else begin
            state_d = FETCH;
          end
        end else begin
          if (push) fetch_pc_d = fetch_pc_q + 32'd4;
          state_d = (count_nx < FULL) ? FETCH : WAIT;
        end
      end
      DRAIN: begin
        if (flush) fetch_pc_d = redir_pc;
        if (bus.mem_ack_i) state_d = FETCH;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (flush) begin
      count_d  = '0;
      rd_ptr_d = wr_ptr_q;
    end else begin
      count_d = count_nx;
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
    end
  end

  // Storage is qualified by count_q, so it needs no reset.
  always_ff @(posedge clk_i) begin
    drain_addr_q <= drain_addr_d;
    if (push) begin
      inst_mem_q[wr_ptr_q] <= bus.mem_rdata_i;
      pc_mem_q[wr_ptr_q]   <= fetch_pc_q;
    end
  end

  assign bus.mem_req_o    = req;
  assign bus.mem_addr_o   = (state_q == DRAIN) ? drain_addr_q : fetch_pc_q;
  assign bus.inst_valid_o = head_vld;
  assign bus.inst_o       = head_vld ? inst_mem_q[rd_ptr_q] : '0;
  assign bus.inst_pc_o    = head_vld ? pc_mem_q[rd_ptr_q] : '0;

endmodule
